// File: rtl/serial_deshifter.sv
// Serial-in/parallel-out receiver: collects WIDTH bits sampled on shift_en cycles and presents
// each completed word in a one-entry holding buffer with a valid/ready handshake. Words that
// complete while the buffer is still full are dropped and flagged by a sticky overrun bit.
module serial_deshifter #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0,
    localparam int unsigned CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             serial_in,
    input  logic             shift_en,
    input  logic             frame_start,
    input  logic             data_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun,
    output logic [CW-1:0]    bit_count
);

    // Holding buffer states; the buffer state bit is data_valid itself.
    localparam logic BUF_EMPTY = 1'b0;
    localparam logic BUF_FULL  = 1'b1;

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             buf_q, buf_d;
    logic             ovr_q, ovr_d;

    logic [WIDTH-1:0] shift_base;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;
    logic             complete;
    logic             transfer;
    logic             buf_free;
    logic             load;
    logic             drop;

    // Collector: shift path and bit counter; frame_start restarts from an empty word.
    always_comb begin
        shift_base = frame_start ? '0 : sreg_q;
        if (LSB_FIRST) begin
            shifted = {serial_in, shift_base[WIDTH-1:1]};
        end else begin
            shifted = {shift_base[WIDTH-2:0], serial_in};
        end

        last_bit = (cnt_q == CW'(WIDTH - 1));
        // A frame_start cycle never completes a word, even on the last bit position.
        complete = shift_en && !frame_start && last_bit;

        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (frame_start) begin
            sreg_d = shift_en ? shifted : '0;
            cnt_d  = shift_en ? CW'(1) : '0;
        end else if (shift_en) begin
            sreg_d = shifted;
            cnt_d  = last_bit ? '0 : cnt_q + CW'(1);
        end
    end

    // Buffer: load, transfer and overrun decisions for the holding register.
    always_comb begin
        transfer = (buf_q == BUF_FULL) && data_ready;
        buf_free = (buf_q == BUF_EMPTY) || data_ready;
        load     = complete && buf_free;
        drop     = complete && !buf_free;

        dout_d = load ? shifted : dout_q;

        buf_d = buf_q;
        if (load) begin
            buf_d = BUF_FULL;
        end else if (transfer) begin
            buf_d = BUF_EMPTY;
        end

        // Setting wins over a coincident clear.
        ovr_d = ovr_q;
        if (drop) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            buf_q  <= BUF_EMPTY;
            ovr_q  <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            buf_q  <= buf_d;
            ovr_q  <= ovr_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = buf_q;
    assign overrun    = ovr_q;
    assign bit_count  = cnt_q;

endmodule

// File: tb/tb_serial_deshifter.sv
// Directed bench for serial_deshifter: an MSB-first and an LSB-first instance share stimulus.
module tb_serial_deshifter;

    logic       clk;
    logic       reset_n;
    logic       serial_in;
    logic       shift_en;
    logic       frame_start;
    logic       data_ready;
    logic       clr_ovr;
    logic [7:0] data_out;
    logic       data_valid;
    logic       overrun;
    logic [2:0] bit_count;
    logic [7:0] l_data_out;
    logic       l_data_valid;
    logic       l_overrun;
    logic [2:0] l_bit_count;

    int checks = 0;
    int errors = 0;

    serial_deshifter #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk         (clk),
        .reset_n     (reset_n),
        .serial_in   (serial_in),
        .shift_en    (shift_en),
        .frame_start (frame_start),
        .data_ready  (data_ready),
        .clr_ovr     (clr_ovr),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .overrun     (overrun),
        .bit_count   (bit_count)
    );

    serial_deshifter #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk         (clk),
        .reset_n     (reset_n),
        .serial_in   (serial_in),
        .shift_en    (shift_en),
        .frame_start (frame_start),
        .data_ready  (data_ready),
        .clr_ovr     (clr_ovr),
        .data_out    (l_data_out),
        .data_valid  (l_data_valid),
        .overrun     (l_overrun),
        .bit_count   (l_bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with current inputs; returns 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends the top n bits of v, MSB first, one per cycle.
    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            shift_en  = 1'b1;
            serial_in = v[7-i];
            tick();
        end
        shift_en  = 1'b0;
        serial_in = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        serial_in   = 1'b0;
        shift_en    = 1'b0;
        frame_start = 1'b0;
        data_ready  = 1'b0;
        clr_ovr     = 1'b0;
        #12;
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        chk("rst_cnt", 32'(bit_count), 32'h0);
        reset_n = 1'b1;
        tick();

        // Test 1/2: 0,0,0,1,0,0,1,0 -> 8'h12 MSB first, 8'h48 LSB first
        data_ready  = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        send_bits(8'h12, 8);
        chk("t1_data", 32'(data_out), 32'h12);
        chk("t1_valid", 32'(data_valid), 32'h1);
        chk("t2_lsb_data", 32'(l_data_out), 32'h48);
        chk("t1_cnt", 32'(bit_count), 32'h0);
        tick();
        chk("t1_valid_drop", 32'(data_valid), 32'h0);

        // Test 3: back-pressure drops the second word
        data_ready = 1'b0;
        send_bits(8'h12, 8);
        chk("t3_first", 32'(data_out), 32'h12);
        chk("t3_ovr_pre", 32'(overrun), 32'h0);
        send_bits(8'h34, 8);
        chk("t3_hold", 32'(data_out), 32'h12);
        chk("t3_ovr", 32'(overrun), 32'h1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("t3_clr", 32'(overrun), 32'h0);
        chk("t3_still_valid", 32'(data_valid), 32'h1);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        chk("t3_consumed", 32'(data_valid), 32'h0);

        // Test 4: transfer and load on the same edge
        send_bits(8'h12, 8);
        send_bits(8'h34, 7);
        data_ready = 1'b1;
        send_bits(8'h00, 1);
        chk("t4_valid", 32'(data_valid), 32'h1);
        chk("t4_data", 32'(data_out), 32'h34);
        chk("t4_ovr", 32'(overrun), 32'h0);
        tick();
        chk("t4_consumed", 32'(data_valid), 32'h0);

        // Test 5: frame_start discards a partial word
        send_bits(8'hE0, 3);
        chk("t5_cnt3", 32'(bit_count), 32'h3);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t5_cnt0", 32'(bit_count), 32'h0);
        send_bits(8'h5A, 8);
        chk("t5_data", 32'(data_out), 32'h5A);
        chk("t5_cnt_after", 32'(bit_count), 32'h0);
        tick();

        // frame_start with shift_en on the last-bit position: bit 1 of a new word, no load
        send_bits(8'hFE, 7);
        frame_start = 1'b1;
        shift_en    = 1'b1;
        serial_in   = 1'b0;
        tick();
        frame_start = 1'b0;
        shift_en    = 1'b0;
        chk("t5b_cnt1", 32'(bit_count), 32'h1);
        chk("t5b_noload", 32'(data_valid), 32'h0);
        data_ready = 1'b0;
        send_bits(8'hAA, 7);
        chk("t5b_data", 32'(data_out), 32'h55);
        chk("t5b_valid", 32'(data_valid), 32'h1);

        // Test 6: asynchronous reset mid-cycle after 5 bits
        send_bits(8'hC3, 5);
        chk("t6_cnt5", 32'(bit_count), 32'h5);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_data", 32'(data_out), 32'h0);
        chk("t6_valid", 32'(data_valid), 32'h0);
        chk("t6_ovr", 32'(overrun), 32'h0);
        chk("t6_cnt", 32'(bit_count), 32'h0);
        #2;
        reset_n = 1'b1;
        send_bits(8'hC3, 8);
        chk("t6_c3", 32'(data_out), 32'hC3);
        chk("t6_c3_valid", 32'(data_valid), 32'h1);

        // Drop coinciding with clr_ovr: set wins
        send_bits(8'hFF, 7);
        clr_ovr = 1'b1;
        send_bits(8'h80, 1);
        clr_ovr = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 32'h1);
        chk("ovr_hold_data", 32'(data_out), 32'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
